// File: rtl/line_wbuffer.sv
// rtl/line_wbuffer.sv - write-back line buffer with merge, lookup and AXI burst drain
module line_wbuffer #(
    parameter int DEPTH        = 8,
    parameter int LINE_WORDS   = 8,
    parameter int DATA_W       = 32,
    parameter int PADDR_W      = 32,
    parameter int DRAIN_THRESH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push_valid,
    output logic                         push_ready,
    input  logic [PADDR_W-1:0]           push_paddr,
    input  logic [LINE_WORDS*DATA_W-1:0] push_data,
    input  logic [PADDR_W-1:0]           lookup_paddr,
    output logic                         lookup_hit,
    output logic [LINE_WORDS*DATA_W-1:0] lookup_data,
    input  logic                         flush_req,
    output logic                         flush_done,
    output logic                         empty,
    output logic                         full,
    output logic [$clog2(DEPTH):0]       count,
    output logic                         bus_err,
    output logic [PADDR_W-1:0]           awaddr,
    output logic [3:0]                   awlen,
    output logic [2:0]                   awsize,
    output logic [1:0]                   awburst,
    output logic                         awvalid,
    input  logic                         awready,
    output logic [DATA_W-1:0]            wdata,
    output logic [DATA_W/8-1:0]          wstrb,
    output logic                         wlast,
    output logic                         wvalid,
    input  logic                         wready,
    input  logic [1:0]                   bresp,
    input  logic                         bvalid,
    output logic                         bready
);
    localparam int LINE_W = LINE_WORDS * DATA_W;
    localparam int OFS    = $clog2(LINE_W / 8);
    localparam int TAG_W  = PADDR_W - OFS;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int IDX_W  = $clog2(LINE_WORDS);

    typedef enum logic [1:0] {S_IDLE, S_AW, S_W, S_B} state_t;

    logic [DEPTH-1:0]  valid_q;
    logic [TAG_W-1:0]  tag_q  [DEPTH];
    logic [LINE_W-1:0] data_q [DEPTH];
    logic [PTR_W-1:0]  head_q, tail_q;
    logic [CNT_W-1:0]  count_q;

    state_t             state_q;
    logic [IDX_W-1:0]   idx_q;
    logic               awvalid_q, wvalid_q, wlast_q, bready_q;
    logic [PADDR_W-1:0] awaddr_q;
    logic [DATA_W-1:0]  wdata_q;
    logic               flush_pending_q, flush_done_q, bus_err_q;

    logic [TAG_W-1:0] push_tag, lookup_tag;
    logic             head_locked;
    logic             merge_hit;
    logic [PTR_W-1:0] merge_idx;
    logic             lk_new_hit, lk_head_hit;
    logic [PTR_W-1:0] lk_new_idx;
    logic             push_fire, do_merge, do_alloc, pop;
    logic [IDX_W-1:0] next_idx;
    logic             unused_ofs;

    assign push_tag    = push_paddr[PADDR_W-1:OFS];
    assign lookup_tag  = lookup_paddr[PADDR_W-1:OFS];
    assign unused_ofs  = ^{push_paddr[OFS-1:0], lookup_paddr[OFS-1:0]};
    assign head_locked = (state_q != S_IDLE);

    // The locked head is excluded from merging; lookup prefers a newer unlocked copy.
    always_comb begin
        merge_hit  = 1'b0;
        merge_idx  = '0;
        lk_new_hit = 1'b0;
        lk_new_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && !(head_locked && (PTR_W'(i) == head_q))) begin
                if (tag_q[i] == push_tag) begin
                    merge_hit = 1'b1;
                    merge_idx = PTR_W'(i);
                end
                if (tag_q[i] == lookup_tag) begin
                    lk_new_hit = 1'b1;
                    lk_new_idx = PTR_W'(i);
                end
            end
        end
        lk_head_hit = head_locked && valid_q[head_q] && (tag_q[head_q] == lookup_tag);
    end

    assign lookup_hit  = lk_new_hit || lk_head_hit;
    assign lookup_data = lk_new_hit  ? data_q[lk_new_idx] :
                         lk_head_hit ? data_q[head_q]     : '0;

    assign full       = (count_q == CNT_W'(DEPTH));
    assign empty      = (count_q == '0);
    assign count      = count_q;
    assign push_ready = !full || merge_hit;
    assign push_fire  = push_valid && push_ready;
    assign do_merge   = push_fire && merge_hit;
    assign do_alloc   = push_fire && !merge_hit;
    assign pop        = (state_q == S_B) && bvalid;
    assign next_idx   = idx_q + IDX_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_alloc) begin
                valid_q[tail_q] <= 1'b1;
                tail_q          <= tail_q + PTR_W'(1);
            end
            if (pop) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + PTR_W'(1);
            end
            case ({do_alloc, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Payload storage needs no reset; it is only observed through valid entries.
    always_ff @(posedge clk) begin
        if (do_merge) begin
            data_q[merge_idx] <= push_data;
        end
        if (do_alloc) begin
            tag_q[tail_q]  <= push_tag;
            data_q[tail_q] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            idx_q           <= '0;
            awvalid_q       <= 1'b0;
            wvalid_q        <= 1'b0;
            wlast_q         <= 1'b0;
            bready_q        <= 1'b0;
            awaddr_q        <= '0;
            wdata_q         <= '0;
            flush_pending_q <= 1'b0;
            flush_done_q    <= 1'b0;
            bus_err_q       <= 1'b0;
        end else begin
            flush_done_q <= 1'b0;
            if (flush_req) begin
                flush_pending_q <= 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if ((count_q >= CNT_W'(DRAIN_THRESH)) || (flush_pending_q && (count_q != '0))) begin
                        state_q   <= S_AW;
                        awvalid_q <= 1'b1;
                        awaddr_q  <= {tag_q[head_q], {OFS{1'b0}}};
                    end else if ((flush_pending_q || flush_req) && (count_q == '0) && !do_alloc) begin
                        flush_done_q    <= 1'b1;
                        flush_pending_q <= 1'b0;
                    end
                end
                S_AW: begin
                    if (awready) begin
                        state_q   <= S_W;
                        awvalid_q <= 1'b0;
                        wvalid_q  <= 1'b1;
                        idx_q     <= '0;
                        wdata_q   <= data_q[head_q][0 +: DATA_W];
                        wlast_q   <= (LINE_WORDS == 1);
                    end
                end
                S_W: begin
                    if (wready) begin
                        if (wlast_q) begin
                            state_q  <= S_B;
                            wvalid_q <= 1'b0;
                            wlast_q  <= 1'b0;
                            bready_q <= 1'b1;
                        end else begin
                            idx_q   <= next_idx;
                            wdata_q <= data_q[head_q][int'(next_idx) * DATA_W +: DATA_W];
                            wlast_q <= (next_idx == IDX_W'(LINE_WORDS - 1));
                        end
                    end
                end
                S_B: begin
                    if (bvalid) begin
                        state_q   <= S_IDLE;
                        bready_q  <= 1'b0;
                        bus_err_q <= bus_err_q | (bresp != 2'b00);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign awaddr     = awaddr_q;
    assign awlen      = 4'(LINE_WORDS - 1);
    assign awsize     = 3'($clog2(DATA_W / 8));
    assign awburst    = 2'b01;
    assign awvalid    = awvalid_q;
    assign wdata      = wdata_q;
    assign wstrb      = '1;
    assign wlast      = wlast_q;
    assign wvalid     = wvalid_q;
    assign bready     = bready_q;
    assign flush_done = flush_done_q;
    assign bus_err    = bus_err_q;
endmodule

// File: tb/tb_line_wbuffer.sv
// tb/tb_line_wbuffer.sv - directed self-checking bench for line_wbuffer
module tb_line_wbuffer;
    logic         clk = 1'b0;
    logic         rst;
    logic         push_valid, push_ready;
    logic [31:0]  push_paddr;
    logic [255:0] push_data;
    logic [31:0]  lookup_paddr;
    logic         lookup_hit;
    logic [255:0] lookup_data;
    logic         flush_req, flush_done, empty, full, bus_err;
    logic [3:0]   count;
    logic [31:0]  awaddr;
    logic [3:0]   awlen;
    logic [2:0]   awsize;
    logic [1:0]   awburst;
    logic         awvalid, awready;
    logic [31:0]  wdata;
    logic [3:0]   wstrb;
    logic         wlast, wvalid, wready;
    logic [1:0]   bresp;
    logic         bvalid, bready;

    int checks = 0;
    int errors = 0;

    line_wbuffer dut (
        .clk(clk), .rst(rst),
        .push_valid(push_valid), .push_ready(push_ready),
        .push_paddr(push_paddr), .push_data(push_data),
        .lookup_paddr(lookup_paddr), .lookup_hit(lookup_hit), .lookup_data(lookup_data),
        .flush_req(flush_req), .flush_done(flush_done),
        .empty(empty), .full(full), .count(count), .bus_err(bus_err),
        .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] mk_line(input logic [31:0] base);
        logic [255:0] r;
        for (int k = 0; k < 8; k++) r[k*32 +: 32] = base + 32'(k);
        return r;
    endfunction

    task automatic push(input logic [31:0] addr, input logic [31:0] base);
        push_valid = 1'b1;
        push_paddr = addr;
        push_data  = mk_line(base);
        step();
        push_valid = 1'b0;
    endtask

    task automatic service_burst(input logic [31:0] exp_addr, input logic [31:0] base, input logic [1:0] resp);
        for (int i = 0; i < 50 && awvalid !== 1'b1; i++) step();
        chk("aw_wait", awvalid, 1'b1);
        chk("awaddr", awaddr, exp_addr);
        awready = 1'b1;
        step();
        awready = 1'b0;
        wready  = 1'b1;
        for (int b = 0; b < 8; b++) begin
            chk("wvalid", wvalid, 1'b1);
            chk("wdata", wdata, base + 32'(b));
            chk("wlast", wlast, (b == 7));
            step();
        end
        wready = 1'b0;
        chk("bready", bready, 1'b1);
        bresp  = resp;
        bvalid = 1'b1;
        step();
        bvalid = 1'b0;
        bresp  = 2'b00;
    endtask

    initial begin
        rst = 1'b1; push_valid = 1'b0; push_paddr = '0; push_data = '0;
        lookup_paddr = '0; flush_req = 1'b0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
        step(); step();
        rst = 1'b0;
        step();

        // Reset state
        chk("rst_push_ready", push_ready, 1'b1);
        chk("rst_empty", empty, 1'b1);
        chk("rst_full", full, 1'b0);
        chk("rst_count", count, 4'd0);
        chk("rst_lookup_hit", lookup_hit, 1'b0);
        chk("rst_lookup_data", lookup_data, 256'd0);
        chk("rst_flush_done", flush_done, 1'b0);
        chk("rst_awvalid", awvalid, 1'b0);
        chk("rst_wvalid", wvalid, 1'b0);
        chk("rst_wlast", wlast, 1'b0);
        chk("rst_bready", bready, 1'b0);
        chk("rst_awaddr", awaddr, 32'd0);
        chk("rst_wdata", wdata, 32'd0);
        chk("rst_bus_err", bus_err, 1'b0);

        // Threshold drain
        push(32'h1000, 32'h1100);
        push(32'h2000, 32'h2200);
        push(32'h3000, 32'h3300);
        chk("thr_count3", count, 4'd3);
        step();
        chk("thr_no_aw", awvalid, 1'b0);
        push(32'h4000, 32'h4400);
        chk("thr_count4", count, 4'd4);
        chk("thr_aw_not_yet", awvalid, 1'b0);
        step();
        chk("thr_aw", awvalid, 1'b1);
        chk("thr_awaddr", awaddr, 32'h1000);
        chk("thr_awlen", awlen, 4'd7);
        chk("thr_awsize", awsize, 3'd2);
        chk("thr_awburst", awburst, 2'b01);
        chk("thr_wstrb", wstrb, 4'hF);
        lookup_paddr = 32'h1010;
        #1;
        chk("thr_lookup_locked_hit", lookup_hit, 1'b1);
        chk("thr_lookup_locked_data", lookup_data, mk_line(32'h1100));
        service_burst(32'h1000, 32'h1100, 2'b00);
        chk("thr_count_after_b", count, 4'd3);
        chk("thr_bready_low", bready, 1'b0);
        chk("thr_line_gone", lookup_hit, 1'b0);
        chk("thr_line_gone_data", lookup_data, 256'd0);
        step();
        chk("thr_idle_below", awvalid, 1'b0);

        // Flush the remaining three lines
        flush_req = 1'b1;
        step();
        flush_req = 1'b0;
        service_burst(32'h2000, 32'h2200, 2'b00);
        service_burst(32'h3000, 32'h3300, 2'b00);
        service_burst(32'h4000, 32'h4400, 2'b00);
        chk("fl_done_early", flush_done, 1'b0);
        chk("fl_empty", empty, 1'b1);
        step();
        chk("fl_done", flush_done, 1'b1);
        step();
        chk("fl_done_pulse", flush_done, 1'b0);

        // Merge
        push(32'h1000, 32'hA000);
        push(32'h1000, 32'hB000);
        chk("mrg_count", count, 4'd1);
        lookup_paddr = 32'h1004;
        #1;
        chk("mrg_hit", lookup_hit, 1'b1);
        chk("mrg_data", lookup_data, mk_line(32'hB000));

        // Push matching the locked head allocates a fresh entry
        flush_req = 1'b1;
        step();
        flush_req = 1'b0;
        step();
        chk("lk_aw", awvalid, 1'b1);
        push(32'h1000, 32'hC000);
        chk("lk_count", count, 4'd2);
        chk("lk_lookup_new", lookup_data, mk_line(32'hC000));
        service_burst(32'h1000, 32'hB000, 2'b00);
        chk("lk_count_after", count, 4'd1);
        service_burst(32'h1000, 32'hC000, 2'b00);
        step();
        chk("lk_flush_done", flush_done, 1'b1);
        chk("lk_empty", empty, 1'b1);

        // Fill to DEPTH while the head burst is stalled
        for (int i = 0; i < 8; i++) push(32'h8000 + 32'(i) * 32'h100, 32'h10000 + 32'(i) * 32'h100);
        chk("full_flag", full, 1'b1);
        chk("full_count", count, 4'd8);
        chk("full_aw", awvalid, 1'b1);
        push_valid = 1'b1;
        push_paddr = 32'h9000;
        #1;
        chk("full_reject_new", push_ready, 1'b0);
        push_paddr = 32'h8000;
        #1;
        chk("full_reject_locked", push_ready, 1'b0);
        push_paddr = 32'h8100;
        #1;
        chk("full_merge_ready", push_ready, 1'b1);
        push_valid = 1'b0;
        push(32'h8100, 32'hEE00);
        chk("full_merge_count", count, 4'd8);
        lookup_paddr = 32'h8100;
        #1;
        chk("full_merge_lookup", lookup_data, mk_line(32'hEE00));

        // Drain all with an error response on the third line
        flush_req = 1'b1;
        step();
        flush_req = 1'b0;
        for (int i = 0; i < 8; i++) begin
            service_burst(32'h8000 + 32'(i) * 32'h100,
                          (i == 1) ? 32'hEE00 : 32'h10000 + 32'(i) * 32'h100,
                          (i == 2) ? 2'b10 : 2'b00);
            chk("err_count", count, 4'(7 - i));
            chk("err_bus_err", bus_err, (i >= 2));
        end
        step();
        chk("err_flush_done", flush_done, 1'b1);

        // Flush while already empty
        step();
        flush_req = 1'b1;
        step();
        flush_req = 1'b0;
        chk("empty_flush_done", flush_done, 1'b1);
        step();
        chk("empty_flush_pulse", flush_done, 1'b0);
        chk("bus_err_sticky", bus_err, 1'b1);

        // Reset in the middle of a burst
        for (int i = 0; i < 4; i++) push(32'h5000 + 32'(i) * 32'h100, 32'h5000);
        for (int i = 0; i < 10 && awvalid !== 1'b1; i++) step();
        awready = 1'b1;
        step();
        awready = 1'b0;
        chk("mid_wvalid", wvalid, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_wvalid", wvalid, 1'b0);
        chk("mid_rst_awvalid", awvalid, 1'b0);
        chk("mid_rst_count", count, 4'd0);
        chk("mid_rst_bus_err", bus_err, 1'b0);
        lookup_paddr = 32'h5000;
        #1;
        chk("mid_rst_lookup", lookup_hit, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/line_wbuffer.md
# line_wbuffer

Parametrised write-back line buffer between the data cache and the AXI write channels. Holds up to DEPTH dirty cache lines, merges repeated writes to the same line, and answers combinational lookups so cache refills see the newest data. Drains lines to memory as single-ID INCR bursts, either continuously above a fill threshold or on an explicit flush.

## Interface
- DEPTH, 8: entry count; power of two, 2..16.
- LINE_WORDS, 8: words per line; power of two, 2..16.
- DATA_W, 32: word width; 32 or 64.
- PADDR_W, 32: physical address width.
- DRAIN_THRESH, 4: occupancy at or above which draining starts without a flush; 1..DEPTH.
- OFS = clog2(LINE_WORDS*DATA_W/8): line offset bits; TAG_W = PADDR_W-OFS.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- push_valid / push_ready  in/out  1  line write handshake.
- push_paddr  in  PADDR_W  line address; offset bits ignored.
- push_data  in  LINE_WORDS*DATA_W  line data; word k is bits [k*DATA_W +: DATA_W].
- lookup_paddr  in  PADDR_W  probe address.
- lookup_hit  out  1  probe line present.
- lookup_data  out  LINE_WORDS*DATA_W  data of the hit entry; 0 on miss.
- flush_req  in  1  one-cycle request to drain everything.
- flush_done  out  1  one-cycle pulse when the flush completes.
- empty, full  out  1  count==0, count==DEPTH.
- count  out  clog2(DEPTH)+1  valid entries.
- bus_err  out  1  sticky; set by bresp!=0.
- awaddr  out  PADDR_W  {tag, OFS zeros}.
- awlen  out  4  const LINE_WORDS-1. awsize  out  3  const clog2(DATA_W/8). awburst  out  2  const 2'b01.
- awvalid / awready  out/in  1.
- wdata  out  DATA_W. wstrb  out  DATA_W/8  all ones. wlast  out  1.
- wvalid / wready  out/in  1.
- bresp  in  2. bvalid / bready  in/out  1.

## Operation
- Storage: circular FIFO of DEPTH entries {valid, tag, data}, head/tail pointers of clog2(DEPTH) bits that wrap naturally.
- Lock: the head entry is locked from entering AW until its B response.
- Merge: push whose tag matches a valid, unlocked entry overwrites that entry's data in place; count unchanged. Merge is accepted even when full.
- Allocate: any other push writes at tail, tail+1, count+1.
- push_ready = !full or (merge match exists).
- Lookup: combinational over valid entries. If the locked head and a newer unlocked entry both match, the unlocked entry is returned.
- Drain FSM states:
  - IDLE: go to AW when count>=DRAIN_THRESH, or when flush_pending and count>0.
  - AW: awvalid=1. On awready go to W with idx=0.
  - W: wvalid=1, wdata=word[idx], wlast=(idx==LINE_WORDS-1). On wready, idx+1; on the last beat go to B.
  - B: bready=1. On bvalid, invalidate head, head+1, count-1, OR (bresp!=0) into bus_err, go to IDLE.
- Only one burst is outstanding at a time.
- A line stays lookup-visible until its B response.
- Flush: flush_req sets flush_pending. When flush_pending, IDLE and count==0, pulse flush_done and clear flush_pending. Pushes during a flush are accepted and also drained before flush_done.

## Timing
- Reset values: all entries invalid, pointers 0, state IDLE, flush_pending 0, bus_err 0.
- Outputs after reset: push_ready=1, empty=1, full=0, count=0, lookup_hit=0, lookup_data=0, flush_done=0, awvalid=wvalid=wlast=bready=0, awaddr=0, wdata=0.
- An accepted push is visible to lookup and count in the next cycle.
- A threshold crossing at edge N gives awvalid at N+1.
- Minimum drain per line: 1 (AW) + LINE_WORDS (W) + 1 (B) cycles.
- Push allocate and B pop in the same cycle: count unchanged. push_ready uses the pre-edge count, so a full buffer rejects a non-merging push even in a pop cycle.
- A push matching the locked head allocates a new entry; the locked data is never modified.
- awvalid/wvalid stay high until handshake; payload is stable while waiting.
- flush_req while already empty and IDLE: flush_done on the next cycle.
- flush_req while flush_pending: no extra effect.
- rst mid-burst: all state is dropped in the next cycle and awvalid/wvalid deassert; the interconnect is reset together with the buffer.

## Test plan
- DEPTH=8, THRESH=4: push 3 distinct lines -> no awvalid, count=3. Push a 4th -> awvalid next cycle with awaddr=line0, awlen=7, 8 beats, wlast on beat 7, count=3 after bvalid.
- Push 0x1000 data A, then 0x1000 data B -> count=1; lookup 0x1004 -> hit, data B.
- Hold awready low, push 0x2000 matching the locked head -> new entry, count+1; lookup returns new data; burst still sends old data.
- Fill to DEPTH with wready=0 -> full=1, non-merging push_ready=0, merging push accepted.
- 2 entries, flush_req -> two bursts, flush_done exactly one cycle after the second bvalid edge, empty=1. flush_req when empty -> flush_done next cycle.
- bresp=2'b10 on one burst -> bus_err=1 held until rst, entry still retired.
